// File: rtl/fifo_credit_sender_pkg.sv
// -----------------------------------------------------------------------------
// kanagawa_credit_pkg
// Shared types and helpers for the credit-based FIFO sender.
//   credit_state_e : sender lifecycle; INIT waits out remote reset skew,
//                    ACTIVE runs for the rest of the reset epoch.
//   credit_width() : bits needed to hold a credit count of 0..depth.
//   credit_count_t : widest credit carrier, for code that must not be
//                    parameterised on DEPTH.
// -----------------------------------------------------------------------------
package kanagawa_credit_pkg;

   typedef enum logic [0:0] {
      INIT   = 1'b0,
      ACTIVE = 1'b1
   } credit_state_e;

   localparam int CREDIT_W_MAX = 16;

   typedef logic [CREDIT_W_MAX-1:0] credit_count_t;

   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_credit_sender_if.sv
// -----------------------------------------------------------------------------
// fifo_credit_sender_if
// Bundles the source handshake, the outbound link and the credit return path
// of fifo_credit_sender.
//   master : the sender itself (drives ready, link, status).
//   slave  : the environment (source, remote FIFO, monitors).
// Signals:
//   src_valid_in / src_data_in / src_ready_out   source handshake
//   link_valid_out / link_data_out               registered link to remote FIFO
//   credit_return_in                             credits coming home per cycle
//   credits_out / low_credit_out / idle_out      status
//   credit_error_out                             sticky protocol error
// -----------------------------------------------------------------------------
interface fifo_credit_sender_if #(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 32,
   parameter int MAX_RETURN = 1
);
   import kanagawa_credit_pkg::*;

   localparam int CW = credit_width(DEPTH);
   localparam int RW = $clog2(MAX_RETURN + 1);

   logic             src_valid_in;
   logic [WIDTH-1:0] src_data_in;
   logic             src_ready_out;
   logic             link_valid_out;
   logic [WIDTH-1:0] link_data_out;
   logic [RW-1:0]    credit_return_in;
   logic [CW-1:0]    credits_out;
   logic             low_credit_out;
   logic             idle_out;
   logic             credit_error_out;

   modport master (
      input  src_valid_in, src_data_in, credit_return_in,
      output src_ready_out, link_valid_out, link_data_out,
             credits_out, low_credit_out, idle_out, credit_error_out
   );

   modport slave (
      output src_valid_in, src_data_in, credit_return_in,
      input  src_ready_out, link_valid_out, link_data_out,
             credits_out, low_credit_out, idle_out, credit_error_out
   );

endinterface

// File: rtl/fifo_credit_sender.sv
// -----------------------------------------------------------------------------
// fifo_credit_sender
// Producer side of a credit-controlled link into a remote receive FIFO.
// Holds one credit per free remote entry, accepts source data only while a
// credit is held, registers accepted data onto the link (1-cycle latency) and
// absorbs credits returned as the remote side pops.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : fifo_credit_sender_if.master (source handshake, link, credit
//          return, status outputs)
// -----------------------------------------------------------------------------
module fifo_credit_sender
   import kanagawa_credit_pkg::*;
#(
   parameter int DEPTH               = 16,
   parameter int WIDTH               = 32,
   parameter int MAX_RETURN          = 1,
   parameter int ALMOST_EMPTY_MARGIN = 1,
   parameter int INIT_CYCLES         = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_credit_sender_if.master bus
);

   localparam int CW = credit_width(DEPTH);
   localparam int RW = $clog2(MAX_RETURN + 1);
   localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [CW:0]   FULL_WIDE = (CW+1)'(DEPTH);
   localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);

   credit_state_e    r_state, w_state_nxt;
   logic [IW-1:0]    r_init_cnt, w_init_cnt_nxt;
   logic [CW-1:0]    r_credits, w_credits_nxt;
   logic             r_err, w_err_nxt;
   logic             r_link_vld;
   logic [WIDTH-1:0] r_link_data;

   logic             w_ready;
   logic             w_accept;
   logic [CW:0]      w_credit_sum;
   logic             w_overflow;

   // Clamp an over-full credit sum back to DEPTH.
   function automatic logic [CW-1:0] sat_credit(input logic [CW:0] sum);
      if (sum > FULL_WIDE) return FULL;
      return sum[CW-1:0];
   endfunction

   // Ready depends only on flops so the source never sees a loop through
   // its own valid or through the credit return path.
   assign w_ready  = (r_state == ACTIVE) && (r_credits != '0);
   assign w_accept = bus.src_valid_in && w_ready;

   // One bit wider than the count so an over-return is visible, not wrapped.
   assign w_credit_sum = {1'b0, r_credits} - (CW+1)'(w_accept)
                       + (CW+1)'(bus.credit_return_in);
   assign w_overflow   = (w_credit_sum > FULL_WIDE);

   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_credits_nxt  = r_credits;
      w_err_nxt      = r_err;
      unique case (r_state)
         INIT: begin
            // The remote side cannot legitimately return anything yet.
            if (bus.credit_return_in != '0) w_err_nxt = 1'b1;
            if (r_init_cnt == '0) begin
               w_credits_nxt = FULL;
               w_state_nxt   = ACTIVE;
            end else begin
               w_init_cnt_nxt = r_init_cnt - IW'(1);
            end
         end
         ACTIVE: begin
            w_credits_nxt = sat_credit(w_credit_sum);
            if (w_overflow) w_err_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = INIT;
         end
      endcase
   end

   // Registered stage: FSM, credit counter and link register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= INIT;
         r_init_cnt  <= INIT_LOAD;
         r_credits   <= '0;
         r_err       <= 1'b0;
         r_link_vld  <= 1'b0;
         r_link_data <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
         r_credits  <= w_credits_nxt;
         r_err      <= w_err_nxt;
         r_link_vld <= w_accept;
         if (w_accept) r_link_data <= bus.src_data_in;
      end
   end

   assign bus.src_ready_out    = w_ready;
   assign bus.link_valid_out   = r_link_vld;
   assign bus.link_data_out    = r_link_data;
   assign bus.credits_out      = r_credits;
   assign bus.low_credit_out   = (r_state == INIT) ||
                                 (r_credits <= CW'(ALMOST_EMPTY_MARGIN));
   assign bus.idle_out         = (r_state == ACTIVE) && (r_credits == FULL) &&
                                 !r_link_vld;
   assign bus.credit_error_out = r_err;

`ifndef SYNTHESIS
   a_return_range : assert property (@(posedge clk) disable iff (rst)
      bus.credit_return_in <= RW'(MAX_RETURN));

   a_credit_bound : assert property (@(posedge clk) disable iff (rst)
      r_credits <= FULL);

   a_src_hold : assert property (@(posedge clk) disable iff (rst)
      (bus.src_valid_in && !w_ready) |=>
         (bus.src_valid_in && $stable(bus.src_data_in)));
`endif

endmodule

// File: tb/tb_fifo_credit_sender.sv
module tb_fifo_credit_sender;

   localparam int DEPTH       = 4;
   localparam int WIDTH       = 32;
   localparam int MAX_RETURN  = 2;
   localparam int MARGIN      = 1;
   localparam int INIT_CYCLES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   fifo_credit_sender_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_RETURN(MAX_RETURN)) u_if ();

   fifo_credit_sender #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_RETURN(MAX_RETURN),
      .ALMOST_EMPTY_MARGIN(MARGIN), .INIT_CYCLES(INIT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: cycles since reset release, plain integer credit pool,
   // and the last accepted word.
   int               m_since   = 0;
   int               m_credits = 0;
   bit               m_lv      = 0;
   bit               m_err     = 0;
   bit               m_acc     = 0;
   bit               m_on      = 0;
   logic [WIDTH-1:0] m_ld      = '0;

   always @(posedge clk) begin
      int tot;
      bit rdy;
      if (rst) begin
         m_since = 0; m_credits = 0; m_lv = 0; m_err = 0; m_acc = 0; m_ld = '0; m_on = 1;
      end else begin
         rdy   = (m_since >= INIT_CYCLES) && (m_credits > 0);
         m_acc = rdy && u_if.src_valid_in;
         if (m_acc) m_ld = u_if.src_data_in;
         m_lv = m_acc;
         if (m_since < INIT_CYCLES) begin
            if (u_if.credit_return_in != 0) m_err = 1;
            m_since++;
            if (m_since == INIT_CYCLES) m_credits = DEPTH;
         end else begin
            tot = m_credits - int'(m_acc) + int'(u_if.credit_return_in);
            if (tot > DEPTH) begin
               m_err = 1;
               tot   = DEPTH;
            end
            m_credits = tot;
         end
      end
   end

   always @(negedge clk) begin
      bit act;
      if (m_on) begin
         act = (m_since >= INIT_CYCLES);
         chk("cmp_ready",   u_if.src_ready_out,    act && (m_credits > 0));
         chk("cmp_lvalid",  u_if.link_valid_out,   m_lv);
         chk("cmp_ldata",   u_if.link_data_out,    m_ld);
         chk("cmp_credits", u_if.credits_out,      m_credits);
         chk("cmp_low",     u_if.low_credit_out,   !act || (m_credits <= MARGIN));
         chk("cmp_idle",    u_if.idle_out,         act && (m_credits == DEPTH) && !m_lv);
         chk("cmp_err",     u_if.credit_error_out, m_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int room, lim, r;
      u_if.src_valid_in     = 1'b0;
      u_if.src_data_in      = '0;
      u_if.credit_return_in = '0;
      repeat (3) step();

      // Reset release and INIT window
      rst = 1'b0;
      chk("t1_c0_credits", u_if.credits_out, 0);
      chk("t1_c0_ready",   u_if.src_ready_out, 0);
      chk("t1_c0_low",     u_if.low_credit_out, 1);
      chk("t1_c0_idle",    u_if.idle_out, 0);
      chk("t1_c0_lvalid",  u_if.link_valid_out, 0);
      step();
      chk("t1_c1_credits", u_if.credits_out, 0);
      chk("t1_c1_ready",   u_if.src_ready_out, 0);
      step();
      chk("t1_c2_credits", u_if.credits_out, 4);
      chk("t1_c2_ready",   u_if.src_ready_out, 1);
      chk("t1_c2_idle",    u_if.idle_out, 1);
      chk("t1_c2_low",     u_if.low_credit_out, 0);

      // Burst until credits run out
      for (int i = 0; i < 4; i++) begin
         u_if.src_valid_in = 1'b1;
         u_if.src_data_in  = 32'hA0 + i;
         step();
         chk("t2_credits", u_if.credits_out, 3 - i);
         chk("t2_lvalid",  u_if.link_valid_out, 1);
         chk("t2_ldata",   u_if.link_data_out, 32'hA0 + i);
         chk("t2_low",     u_if.low_credit_out, (3 - i) <= 1);
      end
      chk("t2_ready_out", u_if.src_ready_out, 0);
      u_if.src_data_in = 32'hA4;
      step();
      chk("t2_lvalid_end", u_if.link_valid_out, 0);
      chk("t2_credits0",   u_if.credits_out, 0);

      // Return at zero credits: ready only on the following cycle
      u_if.credit_return_in = 2'd1;
      #1;
      chk("t3_ready_same", u_if.src_ready_out, 0);
      step();
      u_if.credit_return_in = 2'd0;
      chk("t3_credits1", u_if.credits_out, 1);
      chk("t3_ready1",   u_if.src_ready_out, 1);
      step();
      chk("t3_credits0", u_if.credits_out, 0);
      chk("t3_ldata",    u_if.link_data_out, 32'hA4);
      chk("t3_lvalid",   u_if.link_valid_out, 1);

      // Simultaneous send and return
      u_if.src_valid_in     = 1'b0;
      u_if.credit_return_in = 2'd2;
      step();
      chk("t4_credits2", u_if.credits_out, 2);
      u_if.src_valid_in     = 1'b1;
      u_if.src_data_in      = 32'hB0;
      u_if.credit_return_in = 2'd1;
      step();
      chk("t4_net_zero", u_if.credits_out, 2);
      chk("t4_ldata_b0", u_if.link_data_out, 32'hB0);
      u_if.src_data_in      = 32'hB1;
      u_if.credit_return_in = 2'd2;
      step();
      chk("t4_net_plus", u_if.credits_out, 3);
      u_if.src_valid_in     = 1'b0;
      u_if.credit_return_in = 2'd1;
      step();
      chk("t5_credits4", u_if.credits_out, 4);
      chk("t5_idle",     u_if.idle_out, 1);
      chk("t5_err_pre",  u_if.credit_error_out, 0);

      // Extra return while full
      u_if.credit_return_in = 2'd1;
      step();
      u_if.credit_return_in = 2'd0;
      chk("t5_err_set",  u_if.credit_error_out, 1);
      chk("t5_sat",      u_if.credits_out, 4);
      step();
      chk("t5_err_stky", u_if.credit_error_out, 1);

      // Reset with data in flight
      for (int i = 0; i < 3; i++) begin
         u_if.src_valid_in = 1'b1;
         u_if.src_data_in  = 32'hC0 + i;
         step();
      end
      chk("t6_pre_credits", u_if.credits_out, 1);
      chk("t6_pre_lvalid",  u_if.link_valid_out, 1);
      u_if.src_valid_in = 1'b0;
      rst = 1'b1;
      step();
      chk("t6_lvalid",  u_if.link_valid_out, 0);
      chk("t6_credits", u_if.credits_out, 0);
      chk("t6_err",     u_if.credit_error_out, 0);
      chk("t6_low",     u_if.low_credit_out, 1);
      rst = 1'b0;
      step();
      chk("t6_c1_credits", u_if.credits_out, 0);
      step();
      chk("t6_c2_credits", u_if.credits_out, 4);
      chk("t6_c2_ready",   u_if.src_ready_out, 1);

      // Return during INIT
      rst = 1'b1;
      step();
      rst = 1'b0;
      u_if.credit_return_in = 2'd1;
      step();
      u_if.credit_return_in = 2'd0;
      chk("t5_init_err",     u_if.credit_error_out, 1);
      chk("t5_init_credits", u_if.credits_out, 0);
      step();
      chk("t5_init_reload",  u_if.credits_out, 4);

      // Randomized traffic against the model
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 299) == 0) rst = 1'b1;
         if (!u_if.src_valid_in || m_acc) begin
            u_if.src_valid_in = ($urandom_range(0, 2) != 0);
            u_if.src_data_in  = $urandom;
         end
         if (m_since < INIT_CYCLES) begin
            r = ($urandom_range(0, 99) == 0) ? 1 : 0;
         end else begin
            room = DEPTH - m_credits;
            lim  = (room < MAX_RETURN) ? room : MAX_RETURN;
            r    = $urandom_range(0, lim);
            if ($urandom_range(0, 99) == 0) r = MAX_RETURN;
         end
         u_if.credit_return_in = 2'(r);
         step();
      end
      u_if.src_valid_in     = 1'b0;
      u_if.credit_return_in = 2'd0;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
